tablet_batch_ctrl: RTL and testbench
====================================

Name: tablet_batch_ctrl

Overview:
- Parametrised tablet-bottling controller; successor to the fixed 18-bottle, 2-second-drip filler.
- Accepts a two-digit BCD tablets-per-bottle setting, then meters tablet drops into each bottle and indexes the conveyor between bottles.
- Counts tablets per bottle, bottles per batch and total tablets; the existing display path renders these binary counts.
- New versus the previous generation: runtime pause and abort, external drop-sensor mode, saturating totals, and a proper single-clock FSM.

Parameters:
- MAX_PER_BOTTLE, 50: largest accepted tablets-per-bottle value.
- BOTTLES, 18: bottles per batch.
- TICK_DIV, 200000000: origCP cycles per tablet drop in timer mode (2 s at 100 MHz).
- CONV_TICKS, 400000000: origCP cycles the conveyor runs per index (4 s).
- USE_SENSOR, 0: 0 = internal drop timer; 1 = drops counted from tabDrop rising edges.
- TAB_W, 6: width of per-bottle and setting counters.
- BOT_W, 6: width of bottle counter.
- TOT_W, 12: width of total counter; must satisfy 2^TOT_W > BOTTLES*MAX_PER_BOTTLE.

Ports:
- origCP  in  1  system clock; single clock domain.
- resetN  in  1  asynchronous, active-low reset.
- cfgLoad  in  1  one-cycle strobe; samples highBCD/lowBCD.
- highBCD  in  4  tens digit of setting.
- lowBCD  in  4  ones digit of setting.
- pause  in  1  level; freezes filling and conveyor.
- abort  in  1  one-cycle strobe; cancels the batch.
- tabDrop  in  1  drop sensor, already synchronous to origCP; used only when USE_SENSOR=1.
- tabPerBottle  out  TAB_W  accepted setting.
- curTabs  out  TAB_W  tablets in the current bottle.
- bottlesDone  out  BOT_W  bottles completed this batch.
- totalTabs  out  TOT_W  tablets dispensed since reset; saturating.
- dropEn  out  1  dispenser gate.
- conveyorRun  out  1  conveyor motor.
- cfgErr  out  1  last setting was rejected.
- busy  out  1  state is FILL or MOVE.
- batchDone  out  1  state is DONE.

Behaviour:
- Reset (asynchronous, resetN=0): state IDLE; every output 0; tick counters 0.
- States: IDLE, FILL, MOVE, DONE.
- cfgLoad is honoured only in IDLE or DONE; it is ignored in FILL and MOVE.
- Setting validation: valid iff highBCD<=9, lowBCD<=9, and 1<=value<=MAX_PER_BOTTLE, where value = highBCD*10+lowBCD computed in 7 bits.
- Valid setting: next edge stores tabPerBottle, clears cfgErr, curTabs and bottlesDone, goes to FILL. totalTabs is not cleared.
- Invalid setting: next edge sets cfgErr=1, goes to IDLE (also from DONE); tabPerBottle keeps its old value.
- FILL:
  - dropEn=1 unless pause.
  - A drop event is, in timer mode, the drip tick counter reaching TICK_DIV-1 (counter then wraps to 0); in sensor mode, a tabDrop rising edge (0→1 across consecutive cycles).
  - The drip tick counter advances only in FILL with pause=0, and holds its value while paused.
  - On a drop event: curTabs+1 and totalTabs+1 (held at all-ones once saturated).
  - If the incremented curTabs equals tabPerBottle: bottlesDone+1 in the same edge, go to MOVE.
  - Sensor edges outside FILL, or while paused, are ignored.
- MOVE:
  - conveyorRun=1 unless pause; the conveyor tick counter advances only when not paused.
  - After CONV_TICKS un-paused cycles: curTabs cleared and the drip tick counter reset.
  - Exit goes to DONE if bottlesDone==BOTTLES, else FILL.
- DONE: dropEn=0, conveyorRun=0; all counts hold.
- abort: in any state, next edge goes to IDLE, clears curTabs, bottlesDone and both tick counters, drops dropEn and conveyorRun; totalTabs, tabPerBottle and cfgErr are held.
- Priority when events coincide: resetN > abort > cfgLoad > pause > drop/tick. A drop coinciding with pause is lost (timer mode) or ignored (sensor mode).
- Latency: cfgLoad to dropEn=1 is 1 cycle; a final drop to conveyorRun=1 is 1 cycle.
- Reset asserted mid-batch returns immediately to IDLE with all outputs 0.

Decomposition:
- Package tablets_pkg holds:
  - state enum (IDLE, FILL, MOVE, DONE);
  - BCD_MAX_DIGIT=9;
  - the validation function bcd2_valid(high, low, max).
- One sub-module, tick_gen: parametrised divider with enable, synchronous clear and a terminal-count pulse. It is instantiated twice, once for the drip and once for the conveyor.
- The FSM and counters stay in tablet_batch_ctrl.

Test Plan:
- TICK_DIV=4, CONV_TICKS=3, BOTTLES=3, timer mode:
  - cfgLoad with 0/3 → FILL; curTabs steps 1,2,3 every 4 cycles; MOVE for 3 cycles; repeats; after 9 drops batchDone=1, bottlesDone=3, totalTabs=9.
  - cfgLoad with 5/1 → cfgErr=1, stays IDLE.
  - cfgLoad with 0/0 → cfgErr=1.
  - cfgLoad with 1/10 → cfgErr=1.
  - After any of these, cfgLoad with 0/2 → cfgErr=0, FILL.
  - Assert pause for 10 cycles mid-FILL → dropEn=0, curTabs frozen; resume → next drop arrives exactly after the remaining tick count.
  - abort in MOVE with curTabs=3 → next cycle IDLE, conveyorRun=0, curTabs=0, bottlesDone=0, totalTabs unchanged.
- USE_SENSOR=1:
  - tabDrop held high for 5 cycles in FILL → curTabs+1 exactly once.
  - tabDrop pulses during MOVE → no count.
- resetN driven low asynchronously mid-FILL → all outputs 0 before the next clock edge; cfgLoad while in FILL → ignored.

Source files
------------

// File: rtl/tablets_pkg.sv
// Shared types and setting-validation helpers for the tablet bottling controller.
package tablets_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      MOVE = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int unsigned BCD_MAX_DIGIT = 9;

   function automatic logic [6:0] bcd2_value(input logic [3:0] high, input logic [3:0] low);
      return 7'(high) * 7'd10 + 7'(low);
   endfunction

   // Digit checks come first: an out-of-range tens digit can wrap the 7-bit value into range.
   function automatic logic bcd2_valid(input logic [3:0] high, input logic [3:0] low,
                                       input int unsigned maxValue);
      logic [6:0] value;
      value = bcd2_value(high, low);
      return (high <= 4'(BCD_MAX_DIGIT)) && (low <= 4'(BCD_MAX_DIGIT)) &&
             (value != 7'd0) && ({25'd0, value} <= maxValue);
   endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running divider with enable and synchronous clear; pulses o_tc on the last count.
module tick_gen #(
   parameter int unsigned DIV = 4
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_en,
   input  logic i_clr,
   output logic o_tc
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] r_cnt;
   logic          w_last;

   assign w_last = (r_cnt == CW'(DIV - 1));
   assign o_tc   = i_en && w_last;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= w_last ? '0 : r_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/tablet_batch_ctrl.sv
// Tablet bottling controller: meters drops per bottle, indexes the conveyor,
// and keeps per-bottle, per-batch and lifetime tablet counts.
module tablet_batch_ctrl
   import tablets_pkg::*;
#(
   parameter int unsigned MAX_PER_BOTTLE = 50,
   parameter int unsigned BOTTLES        = 18,
   parameter int unsigned TICK_DIV       = 200000000,
   parameter int unsigned CONV_TICKS     = 400000000,
   parameter int          USE_SENSOR     = 0,
   parameter int unsigned TAB_W          = 6,
   parameter int unsigned BOT_W          = 6,
   parameter int unsigned TOT_W          = 12
) (
   input  logic             origCP,
   input  logic             resetN,
   input  logic             cfgLoad,
   input  logic [3:0]       highBCD,
   input  logic [3:0]       lowBCD,
   input  logic             pause,
   input  logic             abort,
   input  logic             tabDrop,
   output logic [TAB_W-1:0] tabPerBottle,
   output logic [TAB_W-1:0] curTabs,
   output logic [BOT_W-1:0] bottlesDone,
   output logic [TOT_W-1:0] totalTabs,
   output logic             dropEn,
   output logic             conveyorRun,
   output logic             cfgErr,
   output logic             busy,
   output logic             batchDone
);

   state_t           r_state;
   logic [TAB_W-1:0] r_tabPerBottle;
   logic [TAB_W-1:0] r_curTabs;
   logic [BOT_W-1:0] r_bottlesDone;
   logic [TOT_W-1:0] r_totalTabs;
   logic             r_cfgErr;
   logic             r_tabPrev;

   logic             w_cfgAllowed;
   logic             w_cfgValid;
   logic [6:0]       w_cfgValue;
   logic             w_fillRun;
   logic             w_moveRun;
   logic             w_dripTc;
   logic             w_convTc;
   logic             w_drop;
   logic             w_moveExit;
   logic [TAB_W-1:0] w_nextTabs;

   assign w_cfgAllowed = cfgLoad && ((r_state == IDLE) || (r_state == DONE));
   assign w_cfgValid   = bcd2_valid(highBCD, lowBCD, MAX_PER_BOTTLE);
   assign w_cfgValue   = bcd2_value(highBCD, lowBCD);
   assign w_fillRun    = (r_state == FILL) && !pause;
   assign w_moveRun    = (r_state == MOVE) && !pause;
   assign w_moveExit   = w_moveRun && w_convTc;
   assign w_nextTabs   = r_curTabs + TAB_W'(1);

   // Sensor drops only count on a fresh rising edge seen while actively filling.
   assign w_drop = (USE_SENSOR != 0) ? (w_fillRun && tabDrop && !r_tabPrev) : w_dripTc;

   tick_gen #(.DIV(TICK_DIV)) u_dripTick (
      .i_clk   (origCP),
      .i_rst_n (resetN),
      .i_en    (w_fillRun),
      .i_clr   (abort || (w_cfgAllowed && w_cfgValid) || w_moveExit),
      .o_tc    (w_dripTc)
   );

   tick_gen #(.DIV(CONV_TICKS)) u_convTick (
      .i_clk   (origCP),
      .i_rst_n (resetN),
      .i_en    (w_moveRun),
      .i_clr   (abort),
      .o_tc    (w_convTc)
   );

   always_ff @(posedge origCP or negedge resetN) begin
      if (!resetN) begin
         r_state        <= IDLE;
         r_tabPerBottle <= '0;
         r_curTabs      <= '0;
         r_bottlesDone  <= '0;
         r_totalTabs    <= '0;
         r_cfgErr       <= 1'b0;
         r_tabPrev      <= 1'b0;
      end else begin
         r_tabPrev <= tabDrop;
         if (abort) begin
            r_state       <= IDLE;
            r_curTabs     <= '0;
            r_bottlesDone <= '0;
         end else if (w_cfgAllowed) begin
            if (w_cfgValid) begin
               r_tabPerBottle <= TAB_W'(w_cfgValue);
               r_cfgErr       <= 1'b0;
               r_curTabs      <= '0;
               r_bottlesDone  <= '0;
               r_state        <= FILL;
            end else begin
               r_cfgErr <= 1'b1;
               r_state  <= IDLE;
            end
         end else begin
            case (r_state)
               FILL: begin
                  if (w_drop) begin
                     r_curTabs <= w_nextTabs;
                     if (r_totalTabs != '1) begin
                        r_totalTabs <= r_totalTabs + TOT_W'(1);
                     end
                     if (w_nextTabs == r_tabPerBottle) begin
                        r_bottlesDone <= r_bottlesDone + BOT_W'(1);
                        r_state       <= MOVE;
                     end
                  end
               end
               MOVE: begin
                  if (w_moveExit) begin
                     r_curTabs <= '0;
                     r_state   <= (r_bottlesDone == BOT_W'(BOTTLES)) ? DONE : FILL;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

   assign tabPerBottle = r_tabPerBottle;
   assign curTabs      = r_curTabs;
   assign bottlesDone  = r_bottlesDone;
   assign totalTabs    = r_totalTabs;
   assign cfgErr       = r_cfgErr;
   assign dropEn       = (r_state == FILL) && !pause;
   assign conveyorRun  = (r_state == MOVE) && !pause;
   assign busy         = (r_state == FILL) || (r_state == MOVE);
   assign batchDone    = (r_state == DONE);

endmodule

// File: tb/tb_tablet_batch_ctrl.sv
// Bench for tablet_batch_ctrl: a timer-mode instance checked every cycle against a
// behavioural model, plus a sensor-mode instance driven with directed vectors.
module tb_tablet_batch_ctrl;

   localparam int TICK = 4;
   localparam int CONV = 3;
   localparam int NBOT = 3;
   localparam int MAXB = 50;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic resetN = 1'b0;

   logic       cfgLoad = 1'b0;
   logic [3:0] highBCD = 4'd0;
   logic [3:0] lowBCD  = 4'd0;
   logic       pause   = 1'b0;
   logic       abort   = 1'b0;
   logic       tabDrop = 1'b0;
   logic [5:0] tabPerBottle, curTabs, bottlesDone;
   logic [11:0] totalTabs;
   logic       dropEn, conveyorRun, cfgErr, busy, batchDone;

   logic       sCfgLoad = 1'b0;
   logic [3:0] sHighBCD = 4'd0;
   logic [3:0] sLowBCD  = 4'd0;
   logic       sPause   = 1'b0;
   logic       sAbort   = 1'b0;
   logic       sTabDrop = 1'b0;
   logic [5:0] sTabPerBottle, sCurTabs, sBottlesDone;
   logic [11:0] sTotalTabs;
   logic       sDropEn, sConveyorRun, sCfgErr, sBusy, sBatchDone;

   int checks = 0;
   int errors = 0;

   tablet_batch_ctrl #(
      .MAX_PER_BOTTLE(MAXB), .BOTTLES(NBOT), .TICK_DIV(TICK), .CONV_TICKS(CONV),
      .USE_SENSOR(0), .TAB_W(6), .BOT_W(6), .TOT_W(12)
   ) dutTimer (
      .origCP(clock), .resetN(resetN), .cfgLoad(cfgLoad), .highBCD(highBCD),
      .lowBCD(lowBCD), .pause(pause), .abort(abort), .tabDrop(tabDrop),
      .tabPerBottle(tabPerBottle), .curTabs(curTabs), .bottlesDone(bottlesDone),
      .totalTabs(totalTabs), .dropEn(dropEn), .conveyorRun(conveyorRun),
      .cfgErr(cfgErr), .busy(busy), .batchDone(batchDone)
   );

   tablet_batch_ctrl #(
      .MAX_PER_BOTTLE(MAXB), .BOTTLES(NBOT), .TICK_DIV(TICK), .CONV_TICKS(CONV),
      .USE_SENSOR(1), .TAB_W(6), .BOT_W(6), .TOT_W(12)
   ) dutSensor (
      .origCP(clock), .resetN(resetN), .cfgLoad(sCfgLoad), .highBCD(sHighBCD),
      .lowBCD(sLowBCD), .pause(sPause), .abort(sAbort), .tabDrop(sTabDrop),
      .tabPerBottle(sTabPerBottle), .curTabs(sCurTabs), .bottlesDone(sBottlesDone),
      .totalTabs(sTotalTabs), .dropEn(sDropEn), .conveyorRun(sConveyorRun),
      .cfgErr(sCfgErr), .busy(sBusy), .batchDone(sBatchDone)
   );

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s actual %0d expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic applyStimulus(input logic [3:0] hi, input logic [3:0] lo);
      cfgLoad = 1'b1;
      highBCD = hi;
      lowBCD  = lo;
      tick(1);
      cfgLoad = 1'b0;
   endtask

   // Behavioural model of the timer instance: countdowns of remaining active cycles
   // until the next drop and the end of the conveyor index.
   typedef enum {M_IDLE, M_FILL, M_MOVE, M_DONE} mode_t;
   mode_t mMode     = M_IDLE;
   int    mSetting  = 0;
   int    mCur      = 0;
   int    mBottles  = 0;
   int    mTotal    = 0;
   int    mErr      = 0;
   int    mDripLeft = TICK;
   int    mConvLeft = CONV;

   initial forever begin
      int value;
      @(posedge clock or negedge resetN);
      if (!resetN) begin
         mMode = M_IDLE; mSetting = 0; mCur = 0; mBottles = 0; mTotal = 0; mErr = 0;
         mDripLeft = TICK; mConvLeft = CONV;
      end else if (abort) begin
         mMode = M_IDLE; mCur = 0; mBottles = 0; mDripLeft = TICK; mConvLeft = CONV;
      end else if (cfgLoad && (mMode == M_IDLE || mMode == M_DONE)) begin
         value = int'(highBCD) * 10 + int'(lowBCD);
         if (highBCD <= 9 && lowBCD <= 9 && value >= 1 && value <= MAXB) begin
            mSetting = value; mErr = 0; mCur = 0; mBottles = 0; mMode = M_FILL;
            mDripLeft = TICK;
         end else begin
            mErr = 1; mMode = M_IDLE;
         end
      end else if (mMode == M_FILL && !pause) begin
         mDripLeft--;
         if (mDripLeft == 0) begin
            mDripLeft = TICK;
            mCur++;
            if (mTotal < 4095) mTotal++;
            if (mCur == mSetting) begin
               mBottles++; mMode = M_MOVE; mConvLeft = CONV;
            end
         end
      end else if (mMode == M_MOVE && !pause) begin
         mConvLeft--;
         if (mConvLeft == 0) begin
            mCur = 0; mDripLeft = TICK; mConvLeft = CONV;
            mMode = (mBottles == NBOT) ? M_DONE : M_FILL;
         end
      end
   end

   // Every falling edge the timer instance must agree with the model on all outputs.
   initial forever begin
      @(negedge clock);
      checkOutput("mdl_tabPerBottle", int'(tabPerBottle), mSetting);
      checkOutput("mdl_curTabs", int'(curTabs), mCur);
      checkOutput("mdl_bottlesDone", int'(bottlesDone), mBottles);
      checkOutput("mdl_totalTabs", int'(totalTabs), mTotal);
      checkOutput("mdl_cfgErr", int'(cfgErr), mErr);
      checkOutput("mdl_dropEn", int'(dropEn), int'(mMode == M_FILL && !pause));
      checkOutput("mdl_conveyorRun", int'(conveyorRun), int'(mMode == M_MOVE && !pause));
      checkOutput("mdl_busy", int'(busy), int'(mMode == M_FILL || mMode == M_MOVE));
      checkOutput("mdl_batchDone", int'(batchDone), int'(mMode == M_DONE));
   end

   initial begin
      tick(2);
      checkOutput("rst_dropEn", int'(dropEn), 0);
      checkOutput("rst_totalTabs", int'(totalTabs), 0);
      resetN = 1'b1;
      tick(1);

      // Full batch of three bottles, three tablets each.
      applyStimulus(4'd0, 4'd3);
      checkOutput("cfg_dropEn", int'(dropEn), 1);
      checkOutput("cfg_busy", int'(busy), 1);
      tick(4);
      checkOutput("drop1_curTabs", int'(curTabs), 1);
      tick(4);
      checkOutput("drop2_curTabs", int'(curTabs), 2);
      tick(4);
      checkOutput("drop3_curTabs", int'(curTabs), 3);
      checkOutput("drop3_conveyor", int'(conveyorRun), 1);
      checkOutput("drop3_bottles", int'(bottlesDone), 1);
      tick(3);
      checkOutput("move_end_curTabs", int'(curTabs), 0);
      checkOutput("move_end_dropEn", int'(dropEn), 1);
      tick(30);
      checkOutput("batch_done", int'(batchDone), 1);
      checkOutput("batch_bottles", int'(bottlesDone), 3);
      checkOutput("batch_total", int'(totalTabs), 9);

      // Rejected settings, then the upper boundary accepted.
      applyStimulus(4'd5, 4'd1);
      checkOutput("err51_cfgErr", int'(cfgErr), 1);
      checkOutput("err51_keep", int'(tabPerBottle), 3);
      checkOutput("err51_idle", int'(batchDone), 0);
      applyStimulus(4'd0, 4'd0);
      checkOutput("err00_cfgErr", int'(cfgErr), 1);
      applyStimulus(4'd1, 4'd10);
      checkOutput("err1a_cfgErr", int'(cfgErr), 1);
      applyStimulus(4'd15, 4'd0);
      checkOutput("errf0_cfgErr", int'(cfgErr), 1);
      applyStimulus(4'd5, 4'd0);
      checkOutput("ok50_setting", int'(tabPerBottle), 50);
      checkOutput("ok50_cfgErr", int'(cfgErr), 0);
      abort = 1'b1;
      tick(1);
      abort = 1'b0;
      checkOutput("abort_fill_busy", int'(busy), 0);

      // Pause mid-fill: the remaining two ticks resume after the pause.
      applyStimulus(4'd0, 4'd2);
      checkOutput("ok02_setting", int'(tabPerBottle), 2);
      tick(2);
      pause = 1'b1;
      tick(10);
      checkOutput("pause_dropEn", int'(dropEn), 0);
      checkOutput("pause_curTabs", int'(curTabs), 0);
      pause = 1'b0;
      tick(1);
      checkOutput("resume1_curTabs", int'(curTabs), 0);
      tick(1);
      checkOutput("resume2_curTabs", int'(curTabs), 1);
      checkOutput("resume2_total", int'(totalTabs), 10);
      tick(4);
      checkOutput("move2_conveyor", int'(conveyorRun), 1);
      abort = 1'b1;
      tick(1);
      abort = 1'b0;
      checkOutput("abort_move_conveyor", int'(conveyorRun), 0);
      checkOutput("abort_move_curTabs", int'(curTabs), 0);
      checkOutput("abort_move_bottles", int'(bottlesDone), 0);
      checkOutput("abort_move_total", int'(totalTabs), 11);

      // Reload ignored while filling, then asynchronous reset mid-fill.
      applyStimulus(4'd0, 4'd2);
      tick(1);
      applyStimulus(4'd0, 4'd5);
      checkOutput("ignore_cfg_setting", int'(tabPerBottle), 2);
      checkOutput("ignore_cfg_busy", int'(busy), 1);
      @(posedge clock);
      #2;
      resetN = 1'b0;
      #1;
      checkOutput("arst_busy", int'(busy), 0);
      checkOutput("arst_dropEn", int'(dropEn), 0);
      checkOutput("arst_total", int'(totalTabs), 0);
      checkOutput("arst_setting", int'(tabPerBottle), 0);
      tick(1);
      resetN = 1'b1;
      tick(1);

      // Sensor instance: a held-high sensor counts once; pulses in MOVE or pause do not.
      sCfgLoad = 1'b1; sHighBCD = 4'd0; sLowBCD = 4'd2;
      tick(1);
      sCfgLoad = 1'b0;
      checkOutput("s_cfg_dropEn", int'(sDropEn), 1);
      sTabDrop = 1'b1;
      tick(5);
      checkOutput("s_held_curTabs", int'(sCurTabs), 1);
      sTabDrop = 1'b0;
      tick(1);
      sTabDrop = 1'b1;
      tick(1);
      checkOutput("s_second_curTabs", int'(sCurTabs), 2);
      checkOutput("s_second_conveyor", int'(sConveyorRun), 1);
      checkOutput("s_second_bottles", int'(sBottlesDone), 1);
      sTabDrop = 1'b0;
      tick(1);
      sTabDrop = 1'b1;
      tick(1);
      checkOutput("s_move_curTabs", int'(sCurTabs), 2);
      checkOutput("s_move_total", int'(sTotalTabs), 2);
      sTabDrop = 1'b0;
      tick(1);
      checkOutput("s_refill_curTabs", int'(sCurTabs), 0);
      checkOutput("s_refill_dropEn", int'(sDropEn), 1);
      sPause = 1'b1;
      sTabDrop = 1'b1;
      tick(1);
      checkOutput("s_pause_curTabs", int'(sCurTabs), 0);
      sTabDrop = 1'b0;
      tick(1);
      sPause = 1'b0;
      tick(1);
      checkOutput("s_unpause_total", int'(sTotalTabs), 2);
      sTabDrop = 1'b1;
      tick(1);
      sTabDrop = 1'b0;
      checkOutput("s_live_curTabs", int'(sCurTabs), 1);
      checkOutput("s_live_total", int'(sTotalTabs), 3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
